chan_latch_mux: RTL and testbench
=================================

# chan_latch_mux

Parametrised N-channel selector with a registered capture stage. On a capture strobe it latches one W-bit channel from a packed input bus into an output hold register, either the channel named by an explicit select or the next channel of an internal round-robin scan. It sits between the switch/sensor input banks and the display/decoder logic, replacing the fixed 4:1 flag-gated multiplexer.

## Interface
Parameters:
- CH, 8, number of input channels; legal range 2..64, need not be a power of two.
- W, 4, bits per channel; legal ≥ 1.
- SELW, $clog2(CH), select/pointer width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- data  in  CH*W  packed channels; channel k = data[k*W +: W].
- sel  in  SELW  channel index used in direct mode.
- flag  in  1  capture strobe, sampled each rising edge.
- mode  in  1  0 = direct select, 1 = auto-scan.
- clr  in  1  synchronous clear of hold register and scan pointer.
- out_data  out  W  held channel value.
- out_ch  out  SELW  index of the channel held in out_data.
- out_valid  out  1  out_data holds a captured value since the last reset/clr.
- cap  out  1  one-cycle pulse: a capture happened this edge.
- wrap  out  1  one-cycle pulse: scan capture of channel CH-1 (pointer wrapped to 0).
- err  out  1  one-cycle pulse: direct-mode capture requested with sel ≥ CH.

## Operation
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset (rst=1, asynchronous): out_data=0, out_ch=0, out_valid=0, cap=0, wrap=0, err=0, scan pointer ptr=0. Takes effect immediately regardless of clk; ends a scan mid-cycle with no partial capture.
- Priority at each edge: clr > capture > hold.
- clr=1: out_data=0, out_ch=0, out_valid=0, ptr=0; cap/wrap/err=0; flag ignored.
- Hold (flag=0): out_data, out_ch, out_valid, ptr unchanged; pulses drop to 0.
- Direct mode (mode=0, flag=1):
  - sel < CH: out_data ← channel sel, out_ch ← sel, out_valid ← 1, cap=1.
  - sel ≥ CH (only possible when CH is not a power of two): no change to out_data/out_ch/out_valid, err=1, cap=0.
  - ptr held at 0 whenever mode=0.
- Scan mode (mode=1, flag=1):
  - out_data ← channel ptr, out_ch ← ptr, out_valid ← 1, cap=1.
  - ptr ← ptr+1; if ptr == CH-1 then ptr ← 0 and wrap=1.
  - flag=0 cycles pause the scan; ptr is not advanced.
- Mode changes: going 1→0 forces ptr to 0 at that edge; a scan always starts at channel 0 after entering mode 1. The held value stays in place across mode changes until the next capture.
- Data sampled is the value of data at the capturing edge; changes between strobes do not affect out_data.

## Timing
- Latency: capture at edge n; out_data/out_ch/out_valid/cap/wrap/err visible after edge n, stable for the whole cycle n→n+1.
- cap, wrap and err are exactly one cycle wide per qualifying edge. With flag held high in scan mode, cap stays high continuously and wrap pulses once every CH cycles.
- Back-to-back strobes are allowed every cycle with no bubble.
- A flag and clr in the same cycle: the clear wins and no capture occurs.
- rst asserted mid-scan: outputs are 0 immediately. After release, the first scan capture is channel 0.
- Throughput: one capture per clock.

## Test plan
- Reset and hold: assert rst with flag=1 and random data → all outputs 0. Release, flag=0 for 5 cycles → outputs stay 0, out_valid=0.
- Direct capture (CH=8, W=4): data channel k = k+3, sel=5, flag pulse → next cycle out_data=8, out_ch=5, out_valid=1, cap=1 for one cycle. Change data, flag=0 → out_data stays 8.
- Scan with wrap (CH=8): mode=1, flag high for 10 cycles → out_ch sequence 0..7,0,1. wrap=1 only on the cycle out_ch=7. cap high for all 10 cycles.
- Scan pause and mode switch: scan to ptr=3, flag=0 for 3 cycles → out_ch stays 2. mode=0 for 1 cycle then mode=1 with flag → next capture is out_ch=0.
- Out-of-range select (CH=5): sel=6, flag=1 → err=1 for one cycle, cap=0, out_data/out_ch unchanged. sel=4 → out_ch=4, err=0.
- clr priority and async reset mid-scan: flag=1 and clr=1 together → out_valid=0, out_data=0, cap=0. Pulse rst between clock edges during a scan → outputs zero before the next edge; the first scan capture after release is channel 0.

Source files
------------

// File: rtl/chan_latch_mux_if.sv
// Bundle for the channel latch mux: packed input bank, capture controls and held result.
// Latency: none (wires only); timing is set entirely by chan_latch_mux.
// Backpressure: none; the block accepts a capture on any strobed edge.
interface chan_latch_mux_if #(
  parameter int CH = 8,
  parameter int W  = 4
);
  localparam int SELW = $clog2(CH);

  logic [CH*W-1:0] data;
  logic [SELW-1:0] sel;
  logic            flag;
  logic            mode;
  logic            clr;

  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_ch;
  logic            out_valid;
  logic            cap;
  logic            wrap;
  logic            err;

  modport master (
    output data, sel, flag, mode, clr,
    input  out_data, out_ch, out_valid, cap, wrap, err
  );

  modport slave (
    input  data, sel, flag, mode, clr,
    output out_data, out_ch, out_valid, cap, wrap, err
  );
endinterface

// File: rtl/chan_latch_mux.sv
// Channel latch mux: captures one W-bit channel (direct select or round-robin scan) into a hold register.
// Latency: one clock from capture strobe to out_data/out_ch/out_valid and the cap/wrap/err pulses.
// Backpressure: none; a capture is taken on every strobed edge, one per clock, no bubbles.
module chan_latch_mux #(
  parameter int CH = 8,
  parameter int W  = 4,
  localparam int SELW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  chan_latch_mux_if.slave bus
);

  localparam int unsigned     CHU  = CH;
  localparam logic [SELW-1:0] LAST = SELW'(CH - 1);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] idx;
  logic [W-1:0]    pick;
  logic            sel_ok;

  // Direct selects beyond the last channel are only reachable when CH is not a power of two.
  assign sel_ok = (32'(bus.sel) < CHU);

  // Channel index being captured: scan pointer in auto-scan, explicit select otherwise.
  always_comb begin
    idx = bus.mode ? ptr : bus.sel;
  end

  // Compare-based mux so an out-of-range index simply selects nothing.
  always_comb begin
    pick = '0;
    for (int k = 0; k < CH; k++) begin
      if (idx == SELW'(k)) pick = bus.data[k*W +: W];
    end
  end

  // Hold register, scan pointer and one-cycle status pulses; clr beats capture beats hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      bus.cap       <= 1'b0;
      bus.wrap      <= 1'b0;
      bus.err       <= 1'b0;
      ptr           <= '0;
    end else if (bus.clr) begin
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      bus.cap       <= 1'b0;
      bus.wrap      <= 1'b0;
      bus.err       <= 1'b0;
      ptr           <= '0;
    end else begin
      bus.cap  <= 1'b0;
      bus.wrap <= 1'b0;
      bus.err  <= 1'b0;
      // Leaving scan mode parks the pointer so the next scan begins at channel 0.
      if (!bus.mode) ptr <= '0;
      if (bus.flag) begin
        if (bus.mode) begin
          bus.out_data  <= pick;
          bus.out_ch    <= ptr;
          bus.out_valid <= 1'b1;
          bus.cap       <= 1'b1;
          if (ptr == LAST) begin
            ptr      <= '0;
            bus.wrap <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end else if (sel_ok) begin
          bus.out_data  <= pick;
          bus.out_ch    <= bus.sel;
          bus.out_valid <= 1'b1;
          bus.cap       <= 1'b1;
        end else begin
          bus.err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chan_latch_mux.sv
// Bench for chan_latch_mux: CH=8 and CH=5 instances, directed stimulus, queue-based scoreboard.
// Latency: expected capture results are popped one clock after the strobed edge.
// Backpressure: none exercised; strobes are issued back-to-back where the stimulus calls for it.
module tb_chan_latch_mux;

  typedef struct packed {
    logic [3:0] d;
    logic [2:0] ch;
    logic       v;
    logic       c;
    logic       w;
    logic       e;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  exp_t q8[$];
  exp_t q5[$];

  chan_latch_mux_if #(.CH(8), .W(4)) b8 ();
  chan_latch_mux_if #(.CH(5), .W(4)) b5 ();

  chan_latch_mux #(.CH(8), .W(4)) u8 (.clk(clk), .rst(rst), .bus(b8));
  chan_latch_mux #(.CH(5), .W(4)) u5 (.clk(clk), .rst(rst), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int d, int ch, bit v, bit c, bit w, bit e);
    exp_t x;
    x.d  = 4'(d);
    x.ch = 3'(ch);
    x.v  = v;
    x.c  = c;
    x.w  = w;
    x.e  = e;
    return x;
  endfunction

  function automatic exp_t act8();
    return {b8.out_data, b8.out_ch, b8.out_valid, b8.cap, b8.wrap, b8.err};
  endfunction

  function automatic exp_t act5();
    return {b5.out_data, b5.out_ch, b5.out_valid, b5.cap, b5.wrap, b5.err};
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got data=%h ch=%0d valid=%b cap=%b wrap=%b err=%b, need data=%h ch=%0d valid=%b cap=%b wrap=%b err=%b",
               name, act.d, act.ch, act.v, act.c, act.w, act.e,
               req.d, req.ch, req.v, req.c, req.w, req.e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d8;
    logic [31:0] d8s;
    logic [19:0] d5;
    exp_t zero;
    zero = '0;
    n_checks = 0;
    n_fail   = 0;

    rst = 1'b0;
    b8.data = '0; b8.sel = '0; b8.flag = 1'b0; b8.mode = 1'b0; b8.clr = 1'b0;
    b5.data = '0; b5.sel = '0; b5.flag = 1'b0; b5.mode = 1'b0; b5.clr = 1'b0;

    // Scoreboard monitor: pops one expected entry whenever a DUT presents a pulse.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && (b8.cap || b8.wrap || b8.err)) begin
          e = (q8.size() > 0) ? q8.pop_front() : zero;
          check("u8_capture", act8(), e);
        end
        if (!rst && (b5.cap || b5.wrap || b5.err)) begin
          e = (q5.size() > 0) ? q5.pop_front() : zero;
          check("u5_capture", act5(), e);
        end
      end
    join_none

    // Reset with a strobe pending and random data: everything stays zero.
    b8.data = $urandom;
    b5.data = 20'($urandom);
    b8.flag = 1'b1; b8.mode = 1'b1;
    b5.flag = 1'b1; b5.mode = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("reset_async_u8", act8(), zero);
    check("reset_async_u5", act5(), zero);
    tick();
    check("reset_flag_u8", act8(), zero);
    #2 rst = 1'b0;
    b8.flag = 1'b0; b8.mode = 1'b0;
    b5.flag = 1'b0; b5.mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_hold_u8", act8(), zero);
    end
    check("idle_hold_u5", act5(), zero);

    // Direct capture: channel k = k+3, sel=5 gives 8.
    for (int k = 0; k < 8; k++) d8[k*4 +: 4] = 4'(k + 3);
    b8.data = d8; b8.sel = 3'd5; b8.flag = 1'b1;
    q8.push_back(mk(8, 5, 1, 1, 0, 0));
    tick();
    b8.flag = 1'b0; b8.data = ~d8;
    tick();
    check("direct_hold", act8(), mk(8, 5, 1, 0, 0, 0));

    // Scan with wrap: ten strobes walk 0..7,0,1; channel k = 15-k.
    for (int k = 0; k < 8; k++) d8s[k*4 +: 4] = 4'(15 - k);
    b8.data = d8s; b8.mode = 1'b1; b8.flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q8.push_back(mk(15 - (i % 8), i % 8, 1, 1, (i % 8) == 7, 0));
      tick();
    end
    // One more capture (channel 2) leaves the pointer at 3, then pause.
    q8.push_back(mk(13, 2, 1, 1, 0, 0));
    tick();
    b8.flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("scan_pause", act8(), mk(13, 2, 1, 0, 0, 0));
    end

    // Brief drop to direct mode rewinds the scan to channel 0.
    b8.mode = 1'b0;
    tick();
    check("mode_switch_hold", act8(), mk(13, 2, 1, 0, 0, 0));
    b8.mode = 1'b1; b8.flag = 1'b1;
    q8.push_back(mk(15, 0, 1, 1, 0, 0));
    tick();
    b8.flag = 1'b0;
    tick();

    // clr together with a strobe: clear wins, no capture.
    b8.flag = 1'b1; b8.clr = 1'b1;
    tick();
    check("clr_wins", act8(), zero);
    b8.clr = 1'b0;

    // Scan restarts at 0 after clr; async reset pulse between edges mid-scan.
    for (int i = 0; i < 3; i++) begin
      q8.push_back(mk(15 - i, i, 1, 1, 0, 0));
      tick();
    end
    #6 rst = 1'b1;
    #1;
    check("reset_mid_scan", act8(), zero);
    #1 rst = 1'b0;
    q8.push_back(mk(15, 0, 1, 1, 0, 0));
    q8.push_back(mk(14, 1, 1, 1, 0, 0));
    tick();
    tick();
    b8.flag = 1'b0;
    tick();

    // CH=5 direct: in-range, out-of-range (err), then last channel.
    for (int k = 0; k < 5; k++) d5[k*4 +: 4] = 4'(k + 9);
    b5.data = d5; b5.mode = 1'b0; b5.flag = 1'b1; b5.sel = 3'd2;
    q5.push_back(mk(11, 2, 1, 1, 0, 0));
    tick();
    b5.sel = 3'd6;
    q5.push_back(mk(11, 2, 1, 0, 0, 1));
    tick();
    b5.sel = 3'd4;
    q5.push_back(mk(13, 4, 1, 1, 0, 0));
    tick();
    b5.flag = 1'b0;
    tick();
    check("u5_direct_hold", act5(), mk(13, 4, 1, 0, 0, 0));

    // CH=5 scan: 0..4 then 0, wrap on channel 4.
    b5.mode = 1'b1; b5.flag = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q5.push_back(mk(9 + (i % 5), i % 5, 1, 1, (i % 5) == 4, 0));
      tick();
    end
    b5.flag = 1'b0;
    tick();
    tick();

    // Every expected capture must have been presented.
    check("u8_queue_drained", exp_t'(q8.size()), zero);
    check("u5_queue_drained", exp_t'(q5.size()), zero);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
